// File: rtl/vx_wb_pkg.sv
// rtl/vx_wb_pkg.sv - shared constants, source indices and request type for the writeback arbiter
package vx_wb_pkg;

    localparam int NUM_THREADS = 4;
    localparam int UUID_BITS   = 44;
    localparam int NW_BITS     = 2;
    localparam int NR_BITS     = 5;

    localparam int NUM_WB_SRCS = 5;
    localparam int WB_SRC_ALU  = 0;
    localparam int WB_SRC_LSU  = 1;
    localparam int WB_SRC_CSR  = 2;
    localparam int WB_SRC_FPU  = 3;
    localparam int WB_SRC_GPU  = 4;

    localparam int WB_DATAW    = NUM_THREADS * 32;
    localparam int WB_CNT_W    = 64;

    typedef struct packed {
        logic [UUID_BITS-1:0]   uuid;
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            PC;
        logic [NR_BITS-1:0]     rd;
        logic [WB_DATAW-1:0]    data;
        logic                   eop;
    } wb_req_t;

    function automatic int unsigned wb_popcount(input logic [NUM_WB_SRCS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_WB_SRCS; i++) begin
            if (v[i]) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/vx_wb_rr_arbiter.sv
// rtl/vx_wb_rr_arbiter.sv - round-robin arbiter: onehot grant plus index, rotating priority pointer
module vx_wb_rr_arbiter #(
    parameter int NUM_REQS = 5,
    parameter int IDXW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req,
    input  logic                grant_en,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDXW-1:0]     grant_idx,
    output logic                grant_valid
);

    logic [IDXW-1:0] rr_ptr_q;
    logic [IDXW-1:0] rr_ptr_d;
    logic [IDXW:0]   cand_sum;
    logic [IDXW-1:0] cand;

    // Scan candidates starting at rr_ptr, wrapping modulo NUM_REQS; first requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_sum    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
            if (cand_sum >= (IDXW+1)'(NUM_REQS)) begin
                cand_sum = cand_sum - (IDXW+1)'(NUM_REQS);
            end
            cand = cand_sum[IDXW-1:0];
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid && grant_en) begin
            rr_ptr_d = (grant_idx == IDXW'(NUM_REQS-1)) ? '0 : grant_idx + IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/vx_writeback_arb.sv
// rtl/vx_writeback_arb.sv - merges per-unit commits into one registered writeback slot, counts retirements
module vx_writeback_arb
    import vx_wb_pkg::*;
#(
    parameter int NUM_REQS = NUM_WB_SRCS,
    parameter int DATAW    = WB_DATAW,
    parameter int CNT_W    = WB_CNT_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQS-1:0]             cmt_valid,
    output logic [NUM_REQS-1:0]             cmt_ready,
    input  logic [NUM_REQS*UUID_BITS-1:0]   cmt_uuid,
    input  logic [NUM_REQS*NW_BITS-1:0]     cmt_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0] cmt_tmask,
    input  logic [NUM_REQS*32-1:0]          cmt_PC,
    input  logic [NUM_REQS-1:0]             cmt_wb,
    input  logic [NUM_REQS*NR_BITS-1:0]     cmt_rd,
    input  logic [NUM_REQS*DATAW-1:0]       cmt_data,
    input  logic [NUM_REQS-1:0]             cmt_eop,
    output logic                            wb_valid,
    output logic [UUID_BITS-1:0]            wb_uuid,
    output logic [NW_BITS-1:0]              wb_wid,
    output logic [NUM_THREADS-1:0]          wb_tmask,
    output logic [31:0]                     wb_PC,
    output logic [NR_BITS-1:0]              wb_rd,
    output logic [DATAW-1:0]                wb_data,
    output logic                            wb_eop,
    output logic [CNT_W-1:0]                retired_cnt
);

    localparam int IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [NUM_REQS-1:0] wb_req;
    logic [NUM_REQS-1:0] grant;
    logic [NUM_REQS-1:0] fire;
    logic [IDXW-1:0]     grant_idx;
    logic                grant_valid;

    wb_req_t [NUM_REQS-1:0] src;

    wb_req_t          wb_slot_q, wb_slot_d;
    logic             wb_valid_q, wb_valid_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        src = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            src[i].uuid  = cmt_uuid[i*UUID_BITS +: UUID_BITS];
            src[i].wid   = cmt_wid[i*NW_BITS +: NW_BITS];
            src[i].tmask = cmt_tmask[i*NUM_THREADS +: NUM_THREADS];
            src[i].PC    = cmt_PC[i*32 +: 32];
            src[i].rd    = cmt_rd[i*NR_BITS +: NR_BITS];
            src[i].data  = cmt_data[i*DATAW +: DATAW];
            src[i].eop   = cmt_eop[i];
        end
    end

    // Only register-writing commits compete for the slot; reset blocks every grant.
    assign wb_req = cmt_valid & cmt_wb & {NUM_REQS{~reset}};

    vx_wb_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .IDXW     (IDXW)
    ) u_rr_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (wb_req),
        .grant_en    (~reset),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Non-writing commits retire immediately; writers wait for their grant.
    assign cmt_ready = reset ? '0 : (~cmt_wb | grant);
    assign fire      = cmt_valid & cmt_ready;

    always_comb begin
        wb_valid_d    = grant_valid;
        wb_slot_d     = wb_slot_q;
        if (grant_valid) begin
            wb_slot_d = src[grant_idx];
        end
        retired_cnt_d = retired_cnt_q + CNT_W'(wb_popcount(fire & cmt_eop));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q    <= 1'b0;
            wb_slot_q     <= '0;
            retired_cnt_q <= '0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_slot_q     <= wb_slot_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_uuid     = wb_slot_q.uuid;
    assign wb_wid      = wb_slot_q.wid;
    assign wb_tmask    = wb_slot_q.tmask;
    assign wb_PC       = wb_slot_q.PC;
    assign wb_rd       = wb_slot_q.rd;
    assign wb_data     = wb_slot_q.data;
    assign wb_eop      = wb_slot_q.eop;
    assign retired_cnt = retired_cnt_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));

    a_wb_from_one_fire: assert property (@(posedge clk) disable iff (reset)
        wb_valid_q |-> $past($countones(fire & cmt_wb) == 1));

endmodule

// File: tb/tb_vx_writeback_arb.sv
// tb/tb_vx_writeback_arb.sv - scoreboard bench: directed and random commits against a reference model
`timescale 1ns/1ps
module tb_vx_writeback_arb;
    import vx_wb_pkg::*;

    localparam int N  = NUM_WB_SRCS;
    localparam int DW = WB_DATAW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       reset;
    logic [N-1:0]               cmt_valid, cmt_ready, cmt_wb, cmt_eop;
    logic [N*UUID_BITS-1:0]     cmt_uuid;
    logic [N*NW_BITS-1:0]       cmt_wid;
    logic [N*NUM_THREADS-1:0]   cmt_tmask;
    logic [N*32-1:0]            cmt_PC;
    logic [N*NR_BITS-1:0]       cmt_rd;
    logic [N*DW-1:0]            cmt_data;
    logic                       wb_valid;
    logic [UUID_BITS-1:0]       wb_uuid;
    logic [NW_BITS-1:0]         wb_wid;
    logic [NUM_THREADS-1:0]     wb_tmask;
    logic [31:0]                wb_PC;
    logic [NR_BITS-1:0]         wb_rd;
    logic [DW-1:0]              wb_data;
    logic                       wb_eop;
    logic [WB_CNT_W-1:0]        retired_cnt;

    vx_writeback_arb dut (
        .clk (clk), .reset (reset),
        .cmt_valid (cmt_valid), .cmt_ready (cmt_ready), .cmt_uuid (cmt_uuid),
        .cmt_wid (cmt_wid), .cmt_tmask (cmt_tmask), .cmt_PC (cmt_PC),
        .cmt_wb (cmt_wb), .cmt_rd (cmt_rd), .cmt_data (cmt_data), .cmt_eop (cmt_eop),
        .wb_valid (wb_valid), .wb_uuid (wb_uuid), .wb_wid (wb_wid), .wb_tmask (wb_tmask),
        .wb_PC (wb_PC), .wb_rd (wb_rd), .wb_data (wb_data), .wb_eop (wb_eop),
        .retired_cnt (retired_cnt)
    );

    // Per-source pending commit, held stable until it fires.
    logic    p_valid [N];
    logic    p_wb    [N];
    wb_req_t p_req   [N];

    typedef struct { int stamp; wb_req_t req; } exp_wb_t;
    typedef struct { int stamp; logic [WB_CNT_W-1:0] cnt; } exp_cnt_t;
    exp_wb_t  exp_wb_q[$];
    exp_cnt_t exp_cnt_q[$];

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    int m_ptr = 0;
    logic [WB_CNT_W-1:0] m_cnt = '0;

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int j = 0; j < DW/32; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic new_req(input int s, input logic wb, input logic eop,
                           input logic [NR_BITS-1:0] rd, input logic [DW-1:0] data);
        p_valid[s]     = 1'b1;
        p_wb[s]        = wb;
        p_req[s].uuid  = UUID_BITS'({$urandom, $urandom});
        p_req[s].wid   = NW_BITS'($urandom);
        p_req[s].tmask = NUM_THREADS'($urandom);
        p_req[s].PC    = $urandom;
        p_req[s].rd    = rd;
        p_req[s].data  = data;
        p_req[s].eop   = eop;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            cmt_valid[i] = p_valid[i];
            cmt_wb[i]    = p_wb[i];
            cmt_eop[i]   = p_req[i].eop;
            cmt_uuid[i*UUID_BITS +: UUID_BITS]     = p_req[i].uuid;
            cmt_wid[i*NW_BITS +: NW_BITS]          = p_req[i].wid;
            cmt_tmask[i*NUM_THREADS +: NUM_THREADS] = p_req[i].tmask;
            cmt_PC[i*32 +: 32]                     = p_req[i].PC;
            cmt_rd[i*NR_BITS +: NR_BITS]           = p_req[i].rd;
            cmt_data[i*DW +: DW]                   = p_req[i].data;
        end
    endtask

    // One clock: drive, predict ready/fires/winner, advance model, then cross the edge.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        int win;
        int s;
        int n_eop;
        drive();
        #1;
        exp_ready = '0;
        win = -1;
        n_eop = 0;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                s = (m_ptr + k) % N;
                if (win < 0 && p_valid[s] && p_wb[s]) win = s;
            end
            for (int i = 0; i < N; i++) exp_ready[i] = !p_wb[i] || (i == win);
        end
        checks++;
        if (cmt_ready !== exp_ready) begin
            failures++;
            $display("FAIL cmt_ready cycle=%0d got=%b want=%b", edge_n, cmt_ready, exp_ready);
        end
        if (reset) begin
            m_ptr = 0;
            m_cnt = '0;
        end else begin
            if (win >= 0) begin
                exp_wb_q.push_back('{edge_n + 1, p_req[win]});
                m_ptr = (win + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (p_valid[i] && exp_ready[i]) begin
                    if (p_req[i].eop) n_eop++;
                    p_valid[i] = 1'b0;
                end
            end
            m_cnt = m_cnt + WB_CNT_W'(n_eop);
        end
        exp_cnt_q.push_back('{edge_n + 1, m_cnt});
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    always @(negedge clk) begin
        logic    exp_v;
        exp_wb_t e;
        exp_cnt_t c;
        wb_req_t got;
        if (edge_n > 0) begin
            exp_v = (exp_wb_q.size() > 0) && (exp_wb_q[0].stamp == edge_n);
            checks++;
            if (wb_valid !== exp_v) begin
                failures++;
                $display("FAIL wb_valid edge=%0d got=%b want=%b", edge_n, wb_valid, exp_v);
            end
            if (exp_v) begin
                e = exp_wb_q.pop_front();
                if (wb_valid === 1'b1) begin
                    got = '{wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop};
                    checks++;
                    if (got !== e.req) begin
                        failures++;
                        $display("FAIL wb_fields edge=%0d got rd=%0d pc=%h data=%h want rd=%0d pc=%h data=%h",
                                 edge_n, wb_rd, wb_PC, wb_data, e.req.rd, e.req.PC, e.req.data);
                    end
                end
            end
            if (exp_cnt_q.size() > 0 && exp_cnt_q[0].stamp == edge_n) begin
                c = exp_cnt_q.pop_front();
                checks++;
                if (retired_cnt !== c.cnt) begin
                    failures++;
                    $display("FAIL retired_cnt edge=%0d got=%0d want=%0d", edge_n, retired_cnt, c.cnt);
                end
            end
        end
    end

    int lsu_sent;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) new_req(i, 1'b1, 1'b1, NR_BITS'(i), rnd_data());
        repeat (3) cycle();
        checks++;
        if ({wb_valid, wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop, retired_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_state got wb_valid=%b rd=%0d cnt=%0d want all zero", wb_valid, wb_rd, retired_cnt);
        end
        for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
        reset = 1'b0;

        // Single ALU writer
        new_req(WB_SRC_ALU, 1'b1, 1'b1, 5'd5, {4{32'hA5A5A5A5}});
        cycle();
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== {4{32'hA5A5A5A5}}) begin
            failures++;
            $display("FAIL alu_single got valid=%b rd=%0d data=%h want 1 5 a5a5..", wb_valid, wb_rd, wb_data);
        end
        repeat (2) cycle();

        // All five writers at once
        new_req(WB_SRC_ALU, 1'b1, 1'b1, 5'd0, rnd_data());
        new_req(WB_SRC_LSU, 1'b1, 1'b1, 5'd1, rnd_data());
        new_req(WB_SRC_CSR, 1'b1, 1'b1, 5'd2, rnd_data());
        new_req(WB_SRC_FPU, 1'b1, 1'b1, 5'd3, rnd_data());
        new_req(WB_SRC_GPU, 1'b1, 1'b1, 5'd4, rnd_data());
        repeat (7) cycle();

        // Two non-writers plus one writer in the same cycle
        new_req(WB_SRC_CSR, 1'b0, 1'b1, 5'd7, rnd_data());
        new_req(WB_SRC_LSU, 1'b0, 1'b1, 5'd8, rnd_data());
        new_req(WB_SRC_ALU, 1'b1, 1'b1, 5'd9, rnd_data());
        repeat (3) cycle();

        // Multi-packet LSU against a continuous ALU stream
        lsu_sent = 0;
        for (int c = 0; c < 8; c++) begin
            if (!p_valid[WB_SRC_ALU]) new_req(WB_SRC_ALU, 1'b1, 1'b1, NR_BITS'($urandom), rnd_data());
            if (!p_valid[WB_SRC_LSU] && lsu_sent < 4) begin
                new_req(WB_SRC_LSU, 1'b1, (lsu_sent == 3), NR_BITS'(lsu_sent + 16), rnd_data());
                lsu_sent++;
            end
            cycle();
        end
        checks++;
        if (lsu_sent != 4 || p_valid[WB_SRC_LSU]) begin
            failures++;
            $display("FAIL lsu_multi got sent=%0d pending=%b want 4 0", lsu_sent, p_valid[WB_SRC_LSU]);
        end
        repeat (4) cycle();

        // Reset the cycle after a grant
        new_req(WB_SRC_FPU, 1'b1, 1'b1, 5'd11, rnd_data());
        new_req(WB_SRC_GPU, 1'b1, 1'b1, 5'd12, rnd_data());
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || retired_cnt !== '0) begin
            failures++;
            $display("FAIL mid_reset got valid=%b cnt=%0d want 0 0", wb_valid, retired_cnt);
        end
        repeat (4) cycle();

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < N; s++) begin
                if (!p_valid[s] && ($urandom % 3 == 0))
                    new_req(s, ($urandom % 4 != 0), ($urandom % 3 != 0), NR_BITS'($urandom), rnd_data());
            end
            reset = ($urandom % 250 == 0);
            cycle();
        end
        reset = 1'b0;
        repeat (12) cycle();
        @(negedge clk);
        #1;
        checks++;
        if (exp_wb_q.size() != 0 || exp_cnt_q.size() != 0) begin
            failures++;
            $display("FAIL drain got wb_left=%0d cnt_left=%0d want 0 0", exp_wb_q.size(), exp_cnt_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
